// File: rtl/adc_pkg.sv
// Shared definitions for the ADC conversion sequencer and its SIPO capture stage.
// Both blocks import this package so the phase encoding cannot diverge.
package adc_pkg;

  // Phase code driven to the SIPO; the numeric values are part of the interface.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LEAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_LATCH = 2'b11
  } adc_state_t;

  // Resolution of the ADC this sequencer is paired with.
  localparam int ADC_DATA_BITS = 12;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to count down from n-1 to 0, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Sample-period pacing for the conversion sequencer.
// The counter free-runs 0..SAMPLE_PERIOD-1 while enabled and parks at 0 while
// disabled, so the first start after enable rises is immediate.
module adc_period_timer
  import adc_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 32
) (
  input  logic sclk,
  input  logic reset,
  input  logic enable,
  output logic start_tick
);

  localparam int TW = cnt_width(SAMPLE_PERIOD);

  logic [TW-1:0] count;

  // Period counter: wraps at SAMPLE_PERIOD-1, held at zero while disabled.
  always_ff @(posedge sclk) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == TW'(SAMPLE_PERIOD - 1)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // A start is requested once per period, at the top of the count.
  assign start_tick = enable && (count == '0);

endmodule

// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer for one 12-bit serial ADC.
// Walks IDLE -> LEAD -> SHIFT -> LATCH -> IDLE once per sample period, drives
// the ADC chip select, and publishes the phase code consumed by the SIPO.
// Handshake: sample_valid is a one-cycle strobe with no ready; the SIPO word is
// stable for that whole cycle and the consumer must take it then.
module adc_conv_ctrl
  import adc_pkg::*;
#(
  parameter int LEAD_BITS     = 4,
  parameter int DATA_BITS     = ADC_DATA_BITS,
  parameter int QUIET_CYCLES  = 2,
  parameter int SAMPLE_PERIOD = 32
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  state,
  output logic        cs_n,
  output logic        sample_valid,
  output logic [15:0] sample_count,
  output logic        busy
);

  localparam int PW = cnt_width(max3(LEAD_BITS, DATA_BITS, QUIET_CYCLES));

  // Reject parameter sets where a conversion cannot fit inside one period or
  // where the valid strobe would collide with the return to idle.
  if ((SAMPLE_PERIOD < 1 + LEAD_BITS + DATA_BITS + QUIET_CYCLES) ||
      (QUIET_CYCLES < 2) || (LEAD_BITS < 1) || (DATA_BITS < 1)) begin : g_param_check
    $error("adc_conv_ctrl: illegal LEAD/DATA/QUIET/SAMPLE_PERIOD combination");
  end

  adc_state_t    state_q;
  adc_state_t    state_d;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          start_tick;
  logic          valid_d;
  logic [15:0]   count_q;

  adc_period_timer #(
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) u_timer (
    .sclk       (sclk),
    .reset      (reset),
    .enable     (enable),
    .start_tick (start_tick)
  );

  // Next-state and phase-counter reload: each phase loads its length minus one
  // on entry and leaves when the counter reaches zero. A start tick outside
  // IDLE is simply dropped.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_tick) begin
          state_d = S_LEAD;
          phase_d = PW'(LEAD_BITS - 1);
        end
      end
      S_LEAD: begin
        if (phase_q == '0) begin
          state_d = S_SHIFT;
          phase_d = PW'(DATA_BITS - 1);
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      S_SHIFT: begin
        if (phase_q == '0) begin
          state_d = S_LATCH;
          phase_d = PW'(QUIET_CYCLES - 1);
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      S_LATCH: begin
        if (phase_q == '0) begin
          state_d = S_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // The strobe is launched from the first LATCH cycle so that it is visible
  // during the second one, a full cycle after the SIPO latched its word.
  assign valid_d = (state_q == S_LATCH) && (phase_q == PW'(QUIET_CYCLES - 1));

  // FSM registers plus outputs decoded from the next state, so cs_n and busy
  // change on the same edge as the phase code without combinational glitches.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      cs_n         <= 1'b1;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cs_n         <= !((state_d == S_LEAD) || (state_d == S_SHIFT));
      busy         <= (state_d != S_IDLE);
      sample_valid <= valid_d;
      if (valid_d) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign state        = state_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Bench for adc_conv_ctrl at default parameters: a reset/first-conversion
// vector table, hand sequences for the multi-cycle corners, an ADC+SIPO
// behavioural pair, and random enable traffic against a timeline model.
module tb_adc_conv_ctrl;
  import adc_pkg::*;

  localparam int LEAD  = 4;
  localparam int DATA  = 12;
  localparam int QUIET = 2;
  localparam int PER   = 32;
  localparam int TOTAL = LEAD + DATA + QUIET;   // cycles spent outside idle
  localparam int LAT   = LEAD + DATA + 1;       // cs_n fall to sample_valid

  // ---------------- clock / reset / DUT ----------------
  logic        sclk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  state;
  logic        cs_n;
  logic        sample_valid;
  logic [15:0] sample_count;
  logic        busy;

  always #5 sclk = ~sclk;

  adc_conv_ctrl dut (
    .sclk         (sclk),
    .reset        (reset),
    .enable       (enable),
    .state        (state),
    .cs_n         (cs_n),
    .sample_valid (sample_valid),
    .sample_count (sample_count),
    .busy         (busy)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [ADC_DATA_BITS-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- ADC + SIPO behavioural pair ----------------
  // The ADC presents its word MSB first; the SIPO shifts on every SHIFT
  // negedge and copies on the first LATCH negedge.
  logic [ADC_DATA_BITS-1:0] adc_word  = '0;
  logic [ADC_DATA_BITS-1:0] sreg      = '0;
  logic [ADC_DATA_BITS-1:0] sipo_data = '0;
  int   bit_idx    = 0;
  logic prev_latch = 1'b0;

  always @(negedge sclk) begin
    if (state == S_SHIFT) begin
      sreg    <= {sreg[ADC_DATA_BITS-2:0], adc_word[ADC_DATA_BITS-1-bit_idx]};
      bit_idx <= bit_idx + 1;
    end else begin
      bit_idx <= 0;
    end
    if (state == S_LATCH && !prev_latch) sipo_data <= sreg;
    prev_latch <= (state == S_LATCH);
  end

  // ---------------- reference model ----------------
  // A conversion is a timeline: offset 0 is the cs_n fall, phases follow by
  // length, and the word is announced at offset LAT.
  int          m_pc  = 0;
  bit          m_act = 1'b0;
  int          m_off = 0;
  logic [15:0] m_cnt = '0;

  task automatic model_step(input logic r, input logic e);
    bit start;
    if (r) begin
      m_pc = 0; m_act = 1'b0; m_off = 0; m_cnt = '0;
    end else begin
      start = e && (m_pc == 0) && !m_act;
      m_pc  = e ? (m_pc + 1) % PER : 0;
      if (m_act) begin
        m_off++;
        if (m_off >= TOTAL) m_act = 1'b0;
        else if (m_off == LAT) m_cnt++;
      end
      if (start) begin
        m_act = 1'b1;
        m_off = 0;
      end
    end
  endtask

  function automatic logic [1:0] m_state();
    if (!m_act) return 2'b00;
    if (m_off < LEAD) return 2'b01;
    if (m_off < LEAD + DATA) return 2'b10;
    return 2'b11;
  endfunction

  task automatic check_model();
    logic [1:0] s;
    s = m_state();
    chk("model_state", state, s);
    chk("model_cs_n", cs_n, (s == 2'b01 || s == 2'b10) ? 1'b0 : 1'b1);
    chk("model_valid", sample_valid, (m_act && m_off == LAT) ? 1'b1 : 1'b0);
    chk("model_busy", busy, m_act);
    chk("model_count", sample_count, m_cnt);
  endtask

  // ---------------- driver ----------------
  // Inputs change and outputs are observed 1 time unit after the rising edge.
  task automatic tick(input logic r, input logic e);
    reset  = r;
    enable = e;
    @(posedge sclk);
    #1;
    model_step(r, e);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  st;
    logic        csn;
    logic        sv;
    logic        bsy;
    logic [15:0] cnt;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs[NVEC];

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   falls[$];
    int   low_cycles;
    int   pulses;
    bit   got;
    logic prev_csn;

    // Reset for two cycles, then a first conversion from a cold start.
    for (int k = 0; k < NVEC; k++) begin
      int off;
      off = k - 2;
      if (k < 2) begin
        vecs[k] = '{rst: 1'b1, en: 1'b0, st: 2'b00, csn: 1'b1, sv: 1'b0, bsy: 1'b0, cnt: 16'd0};
      end else begin
        vecs[k].rst = 1'b0;
        vecs[k].en  = 1'b1;
        vecs[k].st  = (off < 4) ? 2'b01 : (off < 16) ? 2'b10 : (off < 18) ? 2'b11 : 2'b00;
        vecs[k].csn = (off < 16) ? 1'b0 : 1'b1;
        vecs[k].sv  = (off == 17) ? 1'b1 : 1'b0;
        vecs[k].bsy = (off < 18) ? 1'b1 : 1'b0;
        vecs[k].cnt = (off >= 17) ? 16'd1 : 16'd0;
      end
    end

    for (int k = 0; k < NVEC; k++) begin
      tick(vecs[k].rst, vecs[k].en);
      chk($sformatf("vec%0d_state", k), state, vecs[k].st);
      chk($sformatf("vec%0d_cs_n", k), cs_n, vecs[k].csn);
      chk($sformatf("vec%0d_valid", k), sample_valid, vecs[k].sv);
      chk($sformatf("vec%0d_busy", k), busy, vecs[k].bsy);
      chk($sformatf("vec%0d_count", k), sample_count, vecs[k].cnt);
    end

    // Continuous run: ten conversions, falls one period apart.
    tick(1'b1, 1'b0);
    prev_csn   = cs_n;
    low_cycles = 0;
    for (int t = 1; t <= 10 * PER; t++) begin
      tick(1'b0, 1'b1);
      check_model();
      if (prev_csn && !cs_n) falls.push_back(t);
      if (falls.size() >= 1 && falls.size() < 10 && !busy) low_cycles++;
      prev_csn = cs_n;
    end
    chk("run_fall_count", falls.size(), 10);
    for (int i = 1; i < falls.size(); i++)
      chk($sformatf("run_fall_gap%0d", i), falls[i] - falls[i-1], PER);
    chk("run_count", sample_count, 16'd10);
    chk("run_busy_low", low_cycles, 9 * (PER - TOTAL));

    // ADC data through the SIPO, checked on the sample_valid cycle.
    for (int w = 0; w < 3; w++) begin
      logic [ADC_DATA_BITS-1:0] word;
      word = (w == 0) ? 12'hA5C : (w == 1) ? 12'h000 : 12'hFFF;
      tick(1'b1, 1'b0);
      adc_word = word;
      exp_q.push_back(word);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        tick(1'b0, 1'b1);
        check_model();
        if (sample_valid) begin
          got = 1'b1;
          chk($sformatf("sipo_word%0d", w), sipo_data, exp_q.pop_front());
        end
      end
      chk($sformatf("sipo_seen%0d", w), got, 1'b1);
    end

    // enable dropped during the 5th SHIFT cycle: conversion still completes.
    tick(1'b1, 1'b0);
    for (int i = 0; i < LEAD + 5; i++) tick(1'b0, 1'b1);
    chk("drop_in_shift", state, 2'b10);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b0);
      check_model();
      if (sample_valid) pulses++;
    end
    chk("drop_pulses", pulses, 1);
    chk("drop_count", sample_count, 16'd1);
    chk("drop_idle", state, 2'b00);
    chk("drop_cs_n", cs_n, 1'b1);

    // reset during the 8th SHIFT cycle of a second conversion.
    tick(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("pre_abort_count", sample_count, 16'd1);
    for (int i = 0; i < LEAD + 8; i++) tick(1'b0, 1'b1);
    chk("abort_in_shift", state, 2'b10);
    tick(1'b1, 1'b1);
    chk("abort_state", state, 2'b00);
    chk("abort_cs_n", cs_n, 1'b1);
    chk("abort_valid", sample_valid, 1'b0);
    chk("abort_count", sample_count, 16'd0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, 1'b0);
      check_model();
      if (sample_valid) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);

    // Random enable traffic against the timeline model.
    tick(1'b1, 1'b0);
    begin
      int t;
      t = 0;
      while (t < 1500) begin
        logic e;
        int   len;
        e   = ($urandom_range(0, 3) != 0);
        len = $urandom_range(1, 80);
        for (int i = 0; i < len; i++) begin
          tick(1'b0, e);
          check_model();
        end
        t += len;
      end
    end

    // Count wrap: preload FFFF while idle, then one conversion.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    m_cnt = 16'hFFFF;
    chk("wrap_preload", sample_count, 16'hFFFF);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick(1'b0, 1'b1);
      check_model();
      if (sample_valid) got = 1'b1;
    end
    chk("wrap_seen", got, 1'b1);
    chk("wrap_count", sample_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
